// File: rtl/ghash_pkg.sv
// Shared constants and types for the GHASH engine.
// Build option: define GHASH_DIGIT4_EN to process four multiplier bits per cycle.
package ghash_pkg;

  localparam int GHASH_W = 128;

  // Reduction constant 11100001 || 0^120, stored with GCM bit 0 at index 127
  localparam logic [GHASH_W-1:0] GHASH_R = {8'hE1, 120'd0};

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ghash_state_e;

`ifdef GHASH_DIGIT4_EN
  localparam int GHASH_STEPS = 4;
`else
  localparam int GHASH_STEPS = 1;
`endif

  // One MUL cycle per group of GHASH_STEPS multiplier bits
  localparam int GHASH_CYCLES = GHASH_W / GHASH_STEPS;
  localparam int GHASH_CNT_W  = $clog2(GHASH_CYCLES);
  localparam logic [GHASH_CNT_W-1:0] GHASH_CNT_MAX = GHASH_CNT_W'(GHASH_CYCLES - 1);

endpackage

// File: rtl/ghash_if.sv
// Block/digest bus between the GHASH engine and its surrounding GCM datapath.
interface ghash_if;
  import ghash_pkg::*;

  logic [GHASH_W-1:0] h_in;
  logic               init;
  logic               blk_valid;
  logic               blk_ready;
  logic [GHASH_W-1:0] blk_data;
  logic               blk_last;
  logic [GHASH_W-1:0] y_out;
  logic               y_valid;
  logic               busy;

  modport master (
    output h_in, init, blk_valid, blk_data, blk_last,
    input  blk_ready, y_out, y_valid, busy
  );

  modport slave (
    input  h_in, init, blk_valid, blk_data, blk_last,
    output blk_ready, y_out, y_valid, busy
  );

endinterface

// File: rtl/ghash_gf_step.sv
// One bit-step of the GF(2^128) shift-and-add multiplier (purely combinational).
module ghash_gf_step
  import ghash_pkg::*;
(
  input  logic [GHASH_W-1:0] z,
  input  logic [GHASH_W-1:0] v,
  input  logic               xbit,
  output logic [GHASH_W-1:0] z_n,
  output logic [GHASH_W-1:0] v_n
);

  // Accumulate V when the multiplier bit is set, then multiply V by x with reduction
  always_comb begin
    z_n = xbit ? (z ^ v) : z;
    v_n = v[0] ? ((v >> 1) ^ GHASH_R) : (v >> 1);
  end

endmodule

// File: rtl/ghash_core.sv
// Bit-serial GHASH engine: Y <- (Y ^ X) * H, one block per handshake.
// Build option: GHASH_DIGIT4_EN chains four multiplier steps per cycle.
module ghash_core
  import ghash_pkg::*;
#(
  parameter int WIDTH = GHASH_W
) (
  input  logic   clk,
  input  logic   rst,
  ghash_if.slave bus
);

  ghash_state_e state_q, state_d;

  logic [WIDTH-1:0]       x_q, v_q, z_q, y_q;
  logic [GHASH_CNT_W-1:0] cnt_q;
  logic                   last_q;
  logic                   y_valid_q;
  logic                   ready_c;
  logic                   busy_c;
  logic                   accept;
  logic                   mul_done;

  logic [GHASH_STEPS:0][WIDTH-1:0] z_c;
  logic [GHASH_STEPS:0][WIDTH-1:0] v_c;

  assign accept   = bus.blk_valid && (state_q == IDLE);
  assign mul_done = (state_q == MUL) && (cnt_q == GHASH_CNT_MAX);

  assign z_c[0] = z_q;
  assign v_c[0] = v_q;

  for (genvar k = 0; k < GHASH_STEPS; k++) begin : g_step
    ghash_gf_step u_step (
      .z    (z_c[k]),
      .v    (v_c[k]),
      .xbit (x_q[WIDTH-1-k]),
      .z_n  (z_c[k+1]),
      .v_n  (v_c[k+1])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; ready and busy come from the state register only
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.blk_valid) state_d = MUL;
      end
      MUL: begin
        busy_c = 1'b1;
        if (cnt_q == GHASH_CNT_MAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on acceptance, step the multiplier in MUL, publish Y at exit
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      v_q       <= '0;
      z_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.init) y_q <= '0;
        if (accept) begin
          x_q    <= bus.blk_data ^ (bus.init ? '0 : y_q);
          v_q    <= bus.h_in;
          z_q    <= '0;
          cnt_q  <= '0;
          last_q <= bus.blk_last;
        end
      end else begin
        z_q   <= z_c[GHASH_STEPS];
        v_q   <= v_c[GHASH_STEPS];
        x_q   <= x_q << GHASH_STEPS;
        cnt_q <= cnt_q + GHASH_CNT_W'(1);
        if (mul_done) begin
          y_q       <= z_c[GHASH_STEPS];
          y_valid_q <= last_q;
        end
      end
    end
  end

  assign bus.blk_ready = ready_c;
  assign bus.busy      = busy_c;
  assign bus.y_out     = y_q;
  assign bus.y_valid   = y_valid_q;

endmodule
